// File: rtl/seg_scan_if.sv
// seg_scan_if: load/display bus between frequency logic and the scan controller
interface seg_scan_if #(parameter int DIGITS = 4);
  logic load;
  logic [4*DIGITS-1:0] bcd_in;
  logic ovf_in;
  logic [3:0] dig_code;
  logic [DIGITS-1:0] an;
  logic frame_done;
  logic pending;
  modport master(output load, bcd_in, ovf_in, input dig_code, an, frame_done, pending);
  modport slave(input load, bcd_in, ovf_in, output dig_code, an, frame_done, pending);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment scan with shadowed value, blanking and guard cycles
module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int CLK_DIV = 50000,
  parameter int GUARD = 8,
  parameter int BLANK_LZ = 1
) (
  input logic clk,
  input logic rst,
  seg_scan_if.slave bus
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int GW = $clog2(GUARD + 2);
  localparam int DW = 4 * DIGITS;
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);
  localparam logic [GW-1:0] GLOAD = GW'(GUARD);
  logic [PW-1:0] pcnt;
  logic [IW-1:0] idx;
  logic [GW-1:0] gcnt;
  logic [DW-1:0] shadow, disp;
  logic shadow_ovf, disp_ovf;
  logic tick, boundary, blank;
  logic [3:0] nib, code;
  logic [DIGITS-1:0] lz;
  assign tick = pcnt == PMAX;
  assign boundary = tick && idx == IMAX;
  assign nib = disp[4*idx +: 4];
  assign code = (disp_ovf || nib > 4'd9) ? 4'd10 : nib;
  for (genvar g = 0; g < DIGITS; g++) begin : g_lz
    assign lz[g] = ~|disp[DW-1:4*g];
  end
  assign blank = BLANK_LZ != 0 && !disp_ovf && idx != '0 && lz[idx];
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
      idx <= '0;
      gcnt <= GLOAD;
      shadow <= '0;
      shadow_ovf <= 1'b0;
      disp <= '0;
      disp_ovf <= 1'b0;
      bus.pending <= 1'b0;
      bus.an <= '1;
      bus.dig_code <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      idx <= tick ? (idx == IMAX ? '0 : idx + 1'b1) : idx;
      gcnt <= tick ? GLOAD : (gcnt != '0 ? gcnt - 1'b1 : gcnt);
      if (boundary && bus.pending) begin
        disp <= shadow;
        disp_ovf <= shadow_ovf;
      end
      if (bus.load) begin
        shadow <= bus.bcd_in;
        shadow_ovf <= bus.ovf_in;
      end
      bus.pending <= bus.load || (bus.pending && !boundary);
      bus.frame_done <= boundary && bus.pending;
      bus.dig_code <= code;
      // the tick cycle also blanks so the anode is dark across the digit change
      bus.an <= (gcnt != '0 || tick || blank) ? '1 : ~(DIGITS'(1) << idx);
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl with a cycle-count display model
module tb_seg_scan_ctrl;
  localparam int DIGITS = 4, CLK_DIV = 4, GUARD = 1, BLANK_LZ = 1;
  localparam int FRAME = DIGITS * CLK_DIV;
  typedef struct packed {
    logic [3:0] an;
    logic [3:0] code;
    logic fd;
    logic pend;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, failures = 0, cyc = 0;
  logic [15:0] m_shadow = '0, m_disp = '0;
  logic m_sovf = 1'b0, m_dovf = 1'b0, m_pend = 1'b0;
  exp_t sb[$];
  seg_scan_if #(.DIGITS(DIGITS)) bus();
  seg_scan_ctrl #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .GUARD(GUARD), .BLANK_LZ(BLANK_LZ)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask
  function automatic logic blanked(input int i);
    logic [15:0] t;
    t = m_disp >> (4 * i);
    return BLANK_LZ != 0 && i != 0 && !m_dovf && t == 16'd0;
  endfunction
  task automatic step(input logic r, input logic ld, input logic [15:0] b, input logic o);
    exp_t e;
    int p, ix;
    logic bnd;
    logic [15:0] t;
    p = cyc % CLK_DIV;
    ix = (cyc / CLK_DIV) % DIGITS;
    bnd = p == CLK_DIV - 1 && ix == DIGITS - 1;
    t = m_disp >> (4 * ix);
    if (r) begin
      e.an = 4'hF;
      e.code = 4'd0;
      e.fd = 1'b0;
      e.pend = 1'b0;
    end else begin
      e.code = (m_dovf || t[3:0] > 4'd9) ? 4'd10 : t[3:0];
      e.an = (p >= GUARD && p < CLK_DIV - 1 && !blanked(ix)) ? ~(4'b1 << ix) : 4'hF;
      e.fd = bnd && m_pend;
      e.pend = ld || (m_pend && !bnd);
    end
    sb.push_back(e);
    rst = r;
    bus.load = ld;
    bus.bcd_in = b;
    bus.ovf_in = o;
    if (r) begin
      cyc = 0;
      m_shadow = '0;
      m_sovf = 1'b0;
      m_disp = '0;
      m_dovf = 1'b0;
      m_pend = 1'b0;
    end else begin
      if (bnd && m_pend) begin
        m_disp = m_shadow;
        m_dovf = m_sovf;
      end
      if (bnd) m_pend = 1'b0;
      if (ld) begin
        m_shadow = b;
        m_sovf = o;
        m_pend = 1'b1;
      end
      cyc++;
    end
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check("an", 32'(bus.an), 32'(e.an));
    check("dig_code", 32'(bus.dig_code), 32'(e.code));
    check("frame_done", 32'(bus.frame_done), 32'(e.fd));
    check("pending", 32'(bus.pending), 32'(e.pend));
    check("an_onehot", 32'($countones(~bus.an) <= 1), 32'd1);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
  endtask
  task automatic run_to(input int ph);
    while (cyc % FRAME != ph) step(1'b0, 1'b0, 16'h0, 1'b0);
  endtask
  initial begin
    bus.load = 1'b0;
    bus.bcd_in = '0;
    bus.ovf_in = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h0123, 1'b0);
    idle(3 * FRAME);
    step(1'b0, 1'b1, 16'h0042, 1'b1);
    idle(3 * FRAME);
    run_to(4);
    step(1'b0, 1'b1, 16'h1111, 1'b0);
    run_to(FRAME - 1);
    step(1'b0, 1'b1, 16'h2222, 1'b0);
    idle(3 * FRAME);
    step(1'b0, 1'b1, 16'h00C4, 1'b0);
    step(1'b0, 1'b1, 16'h00C5, 1'b0);
    idle(2 * FRAME);
    step(1'b0, 1'b1, 16'h9000, 1'b0);
    idle(2 * FRAME);
    step(1'b0, 1'b1, 16'h00C5, 1'b0);
    idle(2 * FRAME);
    run_to(5);
    step(1'b0, 1'b1, 16'h3333, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    idle(3 * FRAME);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
